// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//  Instruction fetch stage plus the IF/ID pipeline register.
//  Holds PCF and issues fetches over a req/ack instruction-memory port whose
//  latency is variable (ack may come in the same cycle as req). Applies the
//  hazard-unit stall/flush controls and the EX-stage redirect.
//
//  Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   StallF, StallD        hold PCF / hold IF/ID
//   FlushD                load a bubble into IF/ID
//   PCSrcE, PCTargetE     taken branch/jump redirect from EX
//   imem_req, imem_addr   fetch request and address (address stable until ack)
//   imem_ack, imem_rdata  fetch response, data valid while ack is high
//   InstrD, PCD, PCPlus4D IF/ID register contents
//   ValidD                IF/ID holds a real instruction
//   FetchBusy             imem has not yet returned the word decode is waiting on
// ----------------------------------------------------------------------------
module fetch_stage #(
   parameter int unsigned     XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            StallF,
   input  logic            StallD,
   input  logic            FlushD,
   input  logic            PCSrcE,
   input  logic [XLEN-1:0] PCTargetE,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   output logic [31:0]     InstrD,
   output logic [XLEN-1:0] PCD,
   output logic [XLEN-1:0] PCPlus4D,
   output logic            ValidD,
   output logic            FetchBusy
);

   // StFetch: request for pcF outstanding.
   // StDrop : request for pcF outstanding but already redirected; its data is discarded.
   // StHold : word for pcF is sitting in the hold buffer, no request.
   typedef enum logic [1:0] {StFetch, StDrop, StHold} stateT;

   stateT            state, stateNext;
   logic [XLEN-1:0]  pcF, pcFNext;
   logic [XLEN-1:0]  pendingPc, pendingNext;
   logic [31:0]      holdInstr, holdNext;

   logic [31:0]      instrNext;
   logic [XLEN-1:0]  pcDNext, pcPlus4DNext;
   logic             validNext;

   logic             adv;
   logic             xfer;
   logic [XLEN-1:0]  targetAligned;
   logic [XLEN-1:0]  pcPlus4;
   logic             loadValid;
   logic [31:0]      loadInstr;

   assign adv           = !StallF && !StallD;
   assign xfer          = imem_req && imem_ack;
   assign targetAligned = PCTargetE & {{(XLEN-2){1'b1}}, 2'b00};
   assign pcPlus4       = pcF + {{(XLEN-3){1'b0}}, 3'd4};

   // Request must be low during reset even though the state register says StFetch.
   assign imem_req  = reset_n && (state != StHold);
   assign imem_addr = pcF;
   assign FetchBusy = ((state == StFetch) && !imem_ack) || (state == StDrop);

   // Fetch control: PC, pending redirect, hold buffer and the word offered to IF/ID.
   always_comb begin
      stateNext   = state;
      pcFNext     = pcF;
      pendingNext = pendingPc;
      holdNext    = holdInstr;
      loadValid   = 1'b0;
      loadInstr   = imem_rdata;
      unique case (state)
         StFetch: begin
            if (xfer) begin
               if (PCSrcE) begin
                  pcFNext = targetAligned;
               end else if (adv) begin
                  loadValid = 1'b1;
                  pcFNext   = pcPlus4;
               end else begin
                  holdNext  = imem_rdata;
                  stateNext = StHold;
               end
            end else if (PCSrcE) begin
               // Bus request cannot be withdrawn; remember where to go once it completes.
               pendingNext = targetAligned;
               stateNext   = StDrop;
            end
         end
         StDrop: begin
            if (PCSrcE) pendingNext = targetAligned;
            if (xfer) begin
               pcFNext   = PCSrcE ? targetAligned : pendingPc;
               stateNext = StFetch;
            end
         end
         StHold: begin
            loadInstr = holdInstr;
            if (PCSrcE) begin
               pcFNext   = targetAligned;
               stateNext = StFetch;
            end else if (adv) begin
               loadValid = 1'b1;
               pcFNext   = pcPlus4;
               stateNext = StFetch;
            end
         end
         default: stateNext = StFetch;
      endcase
   end

   // IF/ID next value: flush beats stall beats load; no word means bubble.
   always_comb begin
      instrNext    = NOP_INSTR;
      pcDNext      = '0;
      pcPlus4DNext = '0;
      validNext    = 1'b0;
      if (FlushD) begin
         instrNext = NOP_INSTR;
      end else if (StallD) begin
         instrNext    = InstrD;
         pcDNext      = PCD;
         pcPlus4DNext = PCPlus4D;
         validNext    = ValidD;
      end else if (loadValid) begin
         instrNext    = loadInstr;
         pcDNext      = pcF;
         pcPlus4DNext = pcPlus4;
         validNext    = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= StFetch;
         pcF       <= RESET_PC;
         pendingPc <= '0;
         holdInstr <= NOP_INSTR;
         InstrD    <= NOP_INSTR;
         PCD       <= '0;
         PCPlus4D  <= '0;
         ValidD    <= 1'b0;
      end else begin
         state     <= stateNext;
         pcF       <= pcFNext;
         pendingPc <= pendingNext;
         holdInstr <= holdNext;
         InstrD    <= instrNext;
         PCD       <= pcDNext;
         PCPlus4D  <= pcPlus4DNext;
         ValidD    <= validNext;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        StallF, StallD, FlushD, PCSrcE;
   logic [31:0] PCTargetE;
   logic        imem_req, imem_ack;
   logic [31:0] imem_addr, imem_rdata;
   logic [31:0] InstrD, PCD, PCPlus4D;
   logic        ValidD, FetchBusy;
   logic        ackEn;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc4;
   } fetchT;

   fetchT expQ[$];
   fetchT e;
   int    errors = 0;
   int    checks = 0;

   fetch_stage dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .StallF     (StallF),
      .StallD     (StallD),
      .FlushD     (FlushD),
      .PCSrcE     (PCSrcE),
      .PCTargetE  (PCTargetE),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .InstrD     (InstrD),
      .PCD        (PCD),
      .PCPlus4D   (PCPlus4D),
      .ValidD     (ValidD),
      .FetchBusy  (FetchBusy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] tagOf(input logic [31:0] a);
      return {8'hA5, a[23:0]};
   endfunction

   function automatic fetchT mk(input logic [31:0] p);
      fetchT r;
      r.instr = tagOf(p);
      r.pc    = p;
      r.pc4   = p + 32'd4;
      return r;
   endfunction

   // Instruction memory: address-tagged words, ack gated by the bench.
   assign imem_ack   = imem_req && ackEn;
   assign imem_rdata = imem_ack ? tagOf(imem_addr) : 32'hDEAD_BEEF;

   task automatic drive(input logic a, input logic sf, input logic sd, input logic fl,
                        input logic ps, input logic [31:0] t);
      ackEn = a; StallF = sf; StallD = sd; FlushD = fl; PCSrcE = ps; PCTargetE = t;
      #1;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      repeat (2) @(negedge clk);
      checks++;
      if (imem_req !== 1'b0) begin
         errors++; $display("FAIL reset_req: got %b required 0", imem_req);
      end
      checks++;
      if ({ValidD, InstrD, PCD, PCPlus4D} !== {1'b0, NOP, 32'h0, 32'h0}) begin
         errors++;
         $display("FAIL reset_ifid: got v=%b i=%h pc=%h pc4=%h required v=0 i=%h pc=0 pc4=0",
                  ValidD, InstrD, PCD, PCPlus4D, NOP);
      end
   endtask

   task automatic test_zero_wait;
      logic [31:0] p;
      reset_n = 1'b1;
      #1;
      checks++;
      if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
         errors++; $display("FAIL zw_first_req: got req=%b addr=%h required req=1 addr=0",
                            imem_req, imem_addr);
      end
      p = 32'h0;
      expQ.push_back(mk(p));
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (expQ.size() == 0) begin
            errors++; $display("FAIL zw_load: got pc=%h required a queued entry", PCD);
         end else begin
            e = expQ.pop_front();
            if ({ValidD, InstrD, PCD, PCPlus4D} !== {1'b1, e.instr, e.pc, e.pc4}) begin
               errors++;
               $display("FAIL zw_load: got v=%b i=%h pc=%h pc4=%h required v=1 i=%h pc=%h pc4=%h",
                        ValidD, InstrD, PCD, PCPlus4D, e.instr, e.pc, e.pc4);
            end
         end
         p += 32'd4;
         if (i == 0) expQ.push_back(mk(p));
      end
   endtask

   task automatic test_wait;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      for (int c = 0; c < 3; c++) begin
         if (c > 0) begin
            @(negedge clk);
            checks++;
            if ({ValidD, InstrD} !== {1'b0, NOP}) begin
               errors++; $display("FAIL wait_bubble%0d: got v=%b i=%h required v=0 i=%h",
                                  c, ValidD, InstrD, NOP);
            end
         end
         if (c == 2) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            expQ.push_back(mk(32'h8));
         end
         checks++;
         if ({FetchBusy, imem_addr} !== {(c != 2), 32'h8}) begin
            errors++; $display("FAIL wait_busy%0d: got busy=%b addr=%h required busy=%b addr=8",
                               c, FetchBusy, imem_addr, (c != 2));
         end
      end
      @(negedge clk);
      checks++;
      if (expQ.size() == 0) begin
         errors++; $display("FAIL wait_load: got pc=%h required a queued entry", PCD);
      end else begin
         e = expQ.pop_front();
         if ({ValidD, InstrD, PCD, PCPlus4D} !== {1'b1, e.instr, e.pc, e.pc4}) begin
            errors++;
            $display("FAIL wait_load: got v=%b i=%h pc=%h pc4=%h required v=1 i=%h pc=%h pc4=%h",
                     ValidD, InstrD, PCD, PCPlus4D, e.instr, e.pc, e.pc4);
         end
      end
   endtask

   task automatic test_hold;
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      checks++;
      if ({ValidD, InstrD, PCD} !== {1'b1, tagOf(32'h8), 32'h8}) begin
         errors++; $display("FAIL hold_ifid: got v=%b i=%h pc=%h required v=1 i=%h pc=8",
                            ValidD, InstrD, PCD, tagOf(32'h8));
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      checks++;
      if (imem_req !== 1'b0) begin
         errors++; $display("FAIL hold_req: got %b required 0", imem_req);
      end
      expQ.push_back(mk(32'hC));
      @(negedge clk);
      checks++;
      if (expQ.size() == 0) begin
         errors++; $display("FAIL hold_load: got pc=%h required a queued entry", PCD);
      end else begin
         e = expQ.pop_front();
         if ({ValidD, InstrD, PCD, PCPlus4D} !== {1'b1, e.instr, e.pc, e.pc4}) begin
            errors++;
            $display("FAIL hold_load: got v=%b i=%h pc=%h pc4=%h required v=1 i=%h pc=%h pc4=%h",
                     ValidD, InstrD, PCD, PCPlus4D, e.instr, e.pc, e.pc4);
         end
      end
      checks++;
      if ({imem_req, imem_addr} !== {1'b1, 32'h10}) begin
         errors++; $display("FAIL hold_next_fetch: got req=%b addr=%h required req=1 addr=10",
                            imem_req, imem_addr);
      end
   endtask

   task automatic test_drop;
      logic [31:0] p;
      p = 32'h10;
      expQ.push_back(mk(p));
      repeat (4) begin
         @(negedge clk);
         checks++;
         if (expQ.size() == 0) begin
            errors++; $display("FAIL b2b_load: got pc=%h required a queued entry", PCD);
         end else begin
            e = expQ.pop_front();
            if ({ValidD, InstrD, PCD, PCPlus4D} !== {1'b1, e.instr, e.pc, e.pc4}) begin
               errors++;
               $display("FAIL b2b_load: got v=%b i=%h pc=%h pc4=%h required v=1 i=%h pc=%h pc4=%h",
                        ValidD, InstrD, PCD, PCPlus4D, e.instr, e.pc, e.pc4);
            end
         end
         p += 32'd4;
         if (p != 32'h20) expQ.push_back(mk(p));
      end
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h100);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if ({ValidD, InstrD} !== {1'b0, NOP}) begin
            errors++; $display("FAIL drop_bubble%0d: got v=%b i=%h required v=0 i=%h",
                               c, ValidD, InstrD, NOP);
         end
         if (c == 0) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
         if (c == 1) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
         checks++;
         if (c < 2 && {FetchBusy, imem_addr} !== {1'b1, 32'h20}) begin
            errors++; $display("FAIL drop_addr%0d: got busy=%b addr=%h required busy=1 addr=20",
                               c, FetchBusy, imem_addr);
         end else if (c == 2 && {FetchBusy, imem_addr} !== {1'b0, 32'h100}) begin
            errors++; $display("FAIL drop_redirect: got busy=%b addr=%h required busy=0 addr=100",
                               FetchBusy, imem_addr);
         end
      end
      expQ.push_back(mk(32'h100));
      @(negedge clk);
      checks++;
      if (expQ.size() == 0) begin
         errors++; $display("FAIL drop_load: got pc=%h required a queued entry", PCD);
      end else begin
         e = expQ.pop_front();
         if ({ValidD, InstrD, PCD, PCPlus4D} !== {1'b1, e.instr, e.pc, e.pc4}) begin
            errors++;
            $display("FAIL drop_load: got v=%b i=%h pc=%h pc4=%h required v=1 i=%h pc=%h pc4=%h",
                     ValidD, InstrD, PCD, PCPlus4D, e.instr, e.pc, e.pc4);
         end
      end
   endtask

   task automatic test_hold_redirect;
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      checks++;
      if ({ValidD, PCD} !== {1'b1, 32'h100}) begin
         errors++; $display("FAIL hredir_held: got v=%b pc=%h required v=1 pc=100", ValidD, PCD);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h203);
      checks++;
      if (imem_req !== 1'b0) begin
         errors++; $display("FAIL hredir_req: got %b required 0", imem_req);
      end
      @(negedge clk);
      checks++;
      if ({ValidD, InstrD, PCD} !== {1'b0, NOP, 32'h0}) begin
         errors++; $display("FAIL hredir_bubble: got v=%b i=%h pc=%h required v=0 i=%h pc=0",
                            ValidD, InstrD, PCD, NOP);
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      checks++;
      if ({imem_req, imem_addr} !== {1'b1, 32'h200}) begin
         errors++; $display("FAIL hredir_addr: got req=%b addr=%h required req=1 addr=200",
                            imem_req, imem_addr);
      end
      expQ.push_back(mk(32'h200));
      @(negedge clk);
      checks++;
      if (expQ.size() == 0) begin
         errors++; $display("FAIL hredir_load: got pc=%h required a queued entry", PCD);
      end else begin
         e = expQ.pop_front();
         if ({ValidD, InstrD, PCD, PCPlus4D} !== {1'b1, e.instr, e.pc, e.pc4}) begin
            errors++;
            $display("FAIL hredir_load: got v=%b i=%h pc=%h pc4=%h required v=1 i=%h pc=%h pc4=%h",
                     ValidD, InstrD, PCD, PCPlus4D, e.instr, e.pc, e.pc4);
         end
      end
   endtask

   task automatic test_reset_midwait;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      checks++;
      if ({imem_req, imem_addr} !== {1'b1, 32'h204}) begin
         errors++; $display("FAIL rmid_pre: got req=%b addr=%h required req=1 addr=204",
                            imem_req, imem_addr);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if ({imem_req, ValidD, InstrD, PCD, PCPlus4D} !== {1'b0, 1'b0, NOP, 32'h0, 32'h0}) begin
         errors++;
         $display("FAIL rmid_reset: got req=%b v=%b i=%h pc=%h pc4=%h required req=0 v=0 i=%h pc=0 pc4=0",
                  imem_req, ValidD, InstrD, PCD, PCPlus4D, NOP);
      end
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      checks++;
      if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
         errors++; $display("FAIL rmid_release: got req=%b addr=%h required req=1 addr=0",
                            imem_req, imem_addr);
      end
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      expQ.push_back(mk(32'h0));
      @(negedge clk);
      checks++;
      if (expQ.size() == 0) begin
         errors++; $display("FAIL rmid_load: got pc=%h required a queued entry", PCD);
      end else begin
         e = expQ.pop_front();
         if ({ValidD, InstrD, PCD, PCPlus4D} !== {1'b1, e.instr, e.pc, e.pc4}) begin
            errors++;
            $display("FAIL rmid_load: got v=%b i=%h pc=%h pc4=%h required v=1 i=%h pc=%h pc4=%h",
                     ValidD, InstrD, PCD, PCPlus4D, e.instr, e.pc, e.pc4);
         end
      end
   endtask

   task automatic test_wrap;
      // Redirect with ack in FETCH drops the word; low target bits are cleared.
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
      @(negedge clk);
      checks++;
      if (ValidD !== 1'b0) begin
         errors++; $display("FAIL wrap_drop: got v=%b required v=0", ValidD);
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      checks++;
      if (imem_addr !== 32'hFFFF_FFFC) begin
         errors++; $display("FAIL wrap_target: got addr=%h required fffffffc", imem_addr);
      end
      expQ.push_back(mk(32'hFFFF_FFFC));
      @(negedge clk);
      checks++;
      if (expQ.size() == 0) begin
         errors++; $display("FAIL wrap_load: got pc=%h required a queued entry", PCD);
      end else begin
         e = expQ.pop_front();
         if ({ValidD, InstrD, PCD, PCPlus4D} !== {1'b1, e.instr, e.pc, e.pc4}) begin
            errors++;
            $display("FAIL wrap_load: got v=%b i=%h pc=%h pc4=%h required v=1 i=%h pc=%h pc4=%h",
                     ValidD, InstrD, PCD, PCPlus4D, e.instr, e.pc, e.pc4);
         end
      end
      checks++;
      if (imem_addr !== 32'h0) begin
         errors++; $display("FAIL wrap_addr: got addr=%h required 0", imem_addr);
      end
   endtask

   task automatic test_flush_priority;
      // StallD alone blocks advance; FlushD overrides the stall on IF/ID.
      drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      checks++;
      if ({ValidD, InstrD, PCD} !== {1'b0, NOP, 32'h0}) begin
         errors++; $display("FAIL flush_over_stall: got v=%b i=%h pc=%h required v=0 i=%h pc=0",
                            ValidD, InstrD, PCD, NOP);
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      checks++;
      if (imem_req !== 1'b0) begin
         errors++; $display("FAIL stalld_only_hold: got req=%b required 0", imem_req);
      end
      expQ.push_back(mk(32'h0));
      @(negedge clk);
      checks++;
      if (expQ.size() == 0) begin
         errors++; $display("FAIL flush_load: got pc=%h required a queued entry", PCD);
      end else begin
         e = expQ.pop_front();
         if ({ValidD, InstrD, PCD, PCPlus4D} !== {1'b1, e.instr, e.pc, e.pc4}) begin
            errors++;
            $display("FAIL flush_load: got v=%b i=%h pc=%h pc4=%h required v=1 i=%h pc=%h pc4=%h",
                     ValidD, InstrD, PCD, PCPlus4D, e.instr, e.pc, e.pc4);
         end
      end
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_wait();
      test_hold();
      test_drop();
      test_hold_redirect();
      test_reset_midwait();
      test_wrap();
      test_flush_priority();
      checks++;
      if (expQ.size() != 0) begin
         errors++; $display("FAIL scoreboard_drain: got %0d entries left required 0", expQ.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
